stage_sequencer: RTL and testbench
==================================

STAGE_SEQUENCER -- requirements
Module: stage_sequencer

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 5, number of execution stages (min 2, max 8); stage 0 is fetch, stage NUM_STAGES-1 is writeback.
REQ-002 SHALL have parameter MEM_STAGE, default 3, index of the memory stage (0..NUM_STAGES-1).
REQ-003 SHALL have parameter MEM_WAIT, default 0, extra compute cycles inserted in MEM_STAGE (0..15).
REQ-004 SHALL have parameter CNT_W, default 32, width of the retired-instruction counter.
REQ-005 SHALL have ports, one clock, with synchronous active-low reset:
  clk  in  1  clock; all state updates on its rising edge
  reset_n  in  1  synchronous active-low reset
  stall  in  1  freeze: no state or counter change while 1
  boot_step_done  in  1  current boot phase finished
  halt_req  in  1  stop after current instruction retires
  step_mode  in  1  single-step enable
  step_go  in  1  release one instruction in step mode
  boot_active  out  4  one-hot boot phase: [0] tx 0x99, [1] rx size, [2] rx program, [3] tx 0xAA
  stage_active  out  NUM_STAGES  one-hot stage in compute phase
  latch_enable  out  NUM_STAGES  one-cycle strobe writing pipeline register after stage i
  mem_strobe  out  1  one-cycle RAM/IO access strobe
  io_enable  out  1  stdin/stdout UART service enabled
  pipeline_register_reset_n  out  1  active-low clear of pipeline registers
  running  out  1  instruction execution in progress
  halted  out  1  in HALTED state
  retired_count  out  CNT_W  instructions retired since reset

Function
REQ-006 SHALL implement states INIT, BOOT0..BOOT3, COMPUTE(s), LATCH(s) for s=0..NUM_STAGES-1, STEP_WAIT, HALTED.
REQ-007 SHALL transition INIT->BOOT0 unconditionally; BOOTk->BOOTk+1 when boot_step_done=1; BOOT3->COMPUTE(0) when boot_step_done=1.
REQ-008 SHALL transition COMPUTE(s)->LATCH(s) after 1 cycle, or after 1+MEM_WAIT cycles when s=MEM_STAGE (wait counter cleared on entry).
REQ-009 SHALL transition LATCH(s)->COMPUTE(s+1) for s<NUM_STAGES-1.
REQ-010 SHALL, in LATCH(NUM_STAGES-1), increment retired_count (wrap modulo 2^CNT_W) and go to HALTED if halt_req=1, else STEP_WAIT if step_mode=1, else COMPUTE(0); halt_req has priority over step_mode.
REQ-011 SHALL leave STEP_WAIT for COMPUTE(0) when step_go=1 (or step_mode=0); HALTED is exited only by reset.
REQ-012 SHALL, while stall=1, hold state, wait counter and retired_count unchanged; Moore outputs stay asserted, but latch_enable and mem_strobe are forced 0.
REQ-013 SHALL drive boot_active[k]=1 only in BOOTk; stage_active[s]=1 only in COMPUTE(s).
REQ-014 SHALL drive latch_enable[s]=1 only in LATCH(s) with stall=0.
REQ-015 SHALL drive mem_strobe=1 only in the final cycle of COMPUTE(MEM_STAGE) with stall=0, exactly once per instruction regardless of MEM_WAIT.
REQ-016 SHALL drive pipeline_register_reset_n=0 in INIT and BOOT0..BOOT3, 1 elsewhere.
REQ-017 SHALL drive io_enable=1 and running=1 in COMPUTE/LATCH states; io_enable=1 also in STEP_WAIT; running=0 in STEP_WAIT and HALTED; halted=1 only in HALTED.
REQ-018 SHALL take 2*NUM_STAGES+MEM_WAIT stall-free cycles per instruction, COMPUTE(0) to next COMPUTE(0).
REQ-019 SHALL hold boot_step_done, halt_req, step_go ignored in states where they are not listed as transition conditions.

Reset
REQ-020 SHALL, when reset_n=0 at a rising clk edge, enter INIT, clear wait counter and retired_count, from any state including mid-boot, mid-stall or HALTED; reset overrides stall.
REQ-021 SHALL in INIT drive all outputs 0, including pipeline_register_reset_n=0.

Verification
V-1 Defaults; reset, boot_step_done pulsed once in each BOOTk -> boot_active 0001,0010,0100,1000 in order, then stage_active=00001 with pipeline_register_reset_n=1.
V-2 Defaults, free run 3 instructions -> COMPUTE(0) every 10 cycles, latch_enable sequence 1,2,4,8,16 per instruction, retired_count=3, one mem_strobe per instruction.
V-3 MEM_WAIT=2 -> stage_active[3] high 3 cycles, mem_strobe only on third, period 12 cycles.
V-4 stall=1 for 4 cycles during LATCH(1) -> latch_enable[1] 0 while stalled, fires once after release; period extended by exactly 4.
V-5 step_mode=1 -> STEP_WAIT after each retire, running=0; step_go pulse -> exactly one further instruction; halt_req=1 with step_mode=1 -> HALTED, halted=1.
V-6 CNT_W=4, 17 instructions -> retired_count=1; reset_n=0 mid-COMPUTE(2) -> next cycle INIT, all outputs 0, retired_count=0.

Source files
------------

// File: rtl/stage_sequencer.sv
// Stage sequencer: boot handshake, per-stage compute/latch pacing of a
// multi-cycle CPU pipeline, single-step/halt control and retire counting.
module stage_sequencer #(
    parameter int NUM_STAGES = 5,
    parameter int MEM_STAGE  = 3,
    parameter int MEM_WAIT   = 0,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  stall,
    input  logic                  boot_step_done,
    input  logic                  halt_req,
    input  logic                  step_mode,
    input  logic                  step_go,
    output logic [3:0]            boot_active,
    output logic [NUM_STAGES-1:0] stage_active,
    output logic [NUM_STAGES-1:0] latch_enable,
    output logic                  mem_strobe,
    output logic                  io_enable,
    output logic                  pipeline_register_reset_n,
    output logic                  running,
    output logic                  halted,
    output logic [CNT_W-1:0]      retired_count
);

    typedef enum logic [3:0] {
        ST_INIT      = 4'd0,
        ST_BOOT0     = 4'd1,
        ST_BOOT1     = 4'd2,
        ST_BOOT2     = 4'd3,
        ST_BOOT3     = 4'd4,
        ST_COMPUTE   = 4'd5,
        ST_LATCH     = 4'd6,
        ST_STEP_WAIT = 4'd7,
        ST_HALTED    = 4'd8
    } state_t;

    localparam logic [2:0] LAST_STAGE = 3'(NUM_STAGES - 1);
    localparam logic [2:0] MEM_IDX    = 3'(MEM_STAGE);
    localparam logic [3:0] WAIT_END   = 4'(MEM_WAIT);

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [2:0]              stage_r;
    logic [2:0]              stage_nxt_s;
    logic [3:0]              wait_r;
    logic [3:0]              wait_nxt_s;
    logic                    retire_s;
    logic [CNT_W-1:0]        retired_r;

    logic [3:0]              boot_r;
    logic [3:0]              boot_nxt_s;
    logic [NUM_STAGES-1:0]   stage_act_r;
    logic [NUM_STAGES-1:0]   stage_act_nxt_s;
    logic [NUM_STAGES-1:0]   latch_pend_r;
    logic [NUM_STAGES-1:0]   latch_pend_nxt_s;
    logic                    mem_final_r;
    logic                    mem_final_nxt_s;
    logic                    io_r;
    logic                    io_nxt_s;
    logic                    prr_n_r;
    logic                    prr_n_nxt_s;
    logic                    run_r;
    logic                    run_nxt_s;
    logic                    halt_r;
    logic                    halt_nxt_s;

    function automatic logic [NUM_STAGES-1:0] stage_onehot(input logic [2:0] idx);
        logic [NUM_STAGES-1:0] vec;
        vec = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            vec[i] = (idx == 3'(i));
        end
        return vec;
    endfunction

    // Next-state logic: boot handshake, stage pacing, retire and step/halt decisions
    always_comb begin
        state_nxt_s = state_r;
        stage_nxt_s = stage_r;
        wait_nxt_s  = wait_r;
        retire_s    = 1'b0;
        case (state_r)
            ST_INIT: begin
                state_nxt_s = ST_BOOT0;
            end
            ST_BOOT0: begin
                if (boot_step_done) state_nxt_s = ST_BOOT1;
                else                state_nxt_s = ST_BOOT0;
            end
            ST_BOOT1: begin
                if (boot_step_done) state_nxt_s = ST_BOOT2;
                else                state_nxt_s = ST_BOOT1;
            end
            ST_BOOT2: begin
                if (boot_step_done) state_nxt_s = ST_BOOT3;
                else                state_nxt_s = ST_BOOT2;
            end
            ST_BOOT3: begin
                if (boot_step_done) begin
                    state_nxt_s = ST_COMPUTE;
                    stage_nxt_s = 3'd0;
                    wait_nxt_s  = 4'd0;
                end else begin
                    state_nxt_s = ST_BOOT3;
                end
            end
            ST_COMPUTE: begin
                // The memory stage dwells until the wait counter reaches MEM_WAIT
                if ((stage_r == MEM_IDX) && (wait_r != WAIT_END)) begin
                    wait_nxt_s = wait_r + 4'd1;
                end else begin
                    state_nxt_s = ST_LATCH;
                    wait_nxt_s  = 4'd0;
                end
            end
            ST_LATCH: begin
                if (stage_r == LAST_STAGE) begin
                    retire_s    = 1'b1;
                    stage_nxt_s = 3'd0;
                    if (halt_req)       state_nxt_s = ST_HALTED;
                    else if (step_mode) state_nxt_s = ST_STEP_WAIT;
                    else                state_nxt_s = ST_COMPUTE;
                end else begin
                    state_nxt_s = ST_COMPUTE;
                    stage_nxt_s = stage_r + 3'd1;
                end
            end
            ST_STEP_WAIT: begin
                if (step_go || !step_mode) state_nxt_s = ST_COMPUTE;
                else                       state_nxt_s = ST_STEP_WAIT;
            end
            ST_HALTED: begin
                state_nxt_s = ST_HALTED;
            end
            default: begin
                state_nxt_s = ST_INIT;
                stage_nxt_s = 3'd0;
                wait_nxt_s  = 4'd0;
            end
        endcase
    end

    // Output decode of the upcoming state, so the Moore outputs come straight from flops
    always_comb begin
        boot_nxt_s       = 4'b0000;
        stage_act_nxt_s  = '0;
        latch_pend_nxt_s = '0;
        mem_final_nxt_s  = 1'b0;
        io_nxt_s         = 1'b0;
        prr_n_nxt_s      = 1'b1;
        run_nxt_s        = 1'b0;
        halt_nxt_s       = 1'b0;
        case (state_nxt_s)
            ST_INIT: begin
                prr_n_nxt_s = 1'b0;
            end
            ST_BOOT0: begin
                boot_nxt_s  = 4'b0001;
                prr_n_nxt_s = 1'b0;
            end
            ST_BOOT1: begin
                boot_nxt_s  = 4'b0010;
                prr_n_nxt_s = 1'b0;
            end
            ST_BOOT2: begin
                boot_nxt_s  = 4'b0100;
                prr_n_nxt_s = 1'b0;
            end
            ST_BOOT3: begin
                boot_nxt_s  = 4'b1000;
                prr_n_nxt_s = 1'b0;
            end
            ST_COMPUTE: begin
                stage_act_nxt_s = stage_onehot(stage_nxt_s);
                mem_final_nxt_s = (stage_nxt_s == MEM_IDX) && (wait_nxt_s == WAIT_END);
                io_nxt_s        = 1'b1;
                run_nxt_s       = 1'b1;
            end
            ST_LATCH: begin
                latch_pend_nxt_s = stage_onehot(stage_nxt_s);
                io_nxt_s         = 1'b1;
                run_nxt_s        = 1'b1;
            end
            ST_STEP_WAIT: begin
                io_nxt_s = 1'b1;
            end
            ST_HALTED: begin
                halt_nxt_s = 1'b1;
            end
            default: begin
                prr_n_nxt_s = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs; reset wins over stall, stall freezes everything
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r      <= ST_INIT;
            stage_r      <= 3'd0;
            wait_r       <= 4'd0;
            retired_r    <= '0;
            boot_r       <= 4'b0000;
            stage_act_r  <= '0;
            latch_pend_r <= '0;
            mem_final_r  <= 1'b0;
            io_r         <= 1'b0;
            prr_n_r      <= 1'b0;
            run_r        <= 1'b0;
            halt_r       <= 1'b0;
        end else if (!stall) begin
            state_r      <= state_nxt_s;
            stage_r      <= stage_nxt_s;
            wait_r       <= wait_nxt_s;
            boot_r       <= boot_nxt_s;
            stage_act_r  <= stage_act_nxt_s;
            latch_pend_r <= latch_pend_nxt_s;
            mem_final_r  <= mem_final_nxt_s;
            io_r         <= io_nxt_s;
            prr_n_r      <= prr_n_nxt_s;
            run_r        <= run_nxt_s;
            halt_r       <= halt_nxt_s;
            if (retire_s) begin
                retired_r <= retired_r + CNT_W'(1);
            end
        end
    end

    // Strobes are suppressed combinationally during a stall so nothing is written twice
    assign latch_enable              = latch_pend_r & {NUM_STAGES{~stall}};
    assign mem_strobe                = mem_final_r & ~stall;
    assign boot_active               = boot_r;
    assign stage_active              = stage_act_r;
    assign io_enable                 = io_r;
    assign pipeline_register_reset_n = prr_n_r;
    assign running                   = run_r;
    assign halted                    = halt_r;
    assign retired_count             = retired_r;

endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: a default instance and one with MEM_WAIT=2, CNT_W=4,
// driven cycle by cycle with expected outputs queued and checked at the falling edge.
module tb_stage_sequencer;

    typedef struct packed {
        logic rst_n;
        logic stall;
        logic bsd;
        logic hreq;
        logic smode;
        logic sgo;
    } ins_t;

    typedef struct packed {
        logic [3:0]  boot;
        logic [4:0]  stage;
        logic [4:0]  latch;
        logic        mem;
        logic        io;
        logic        prr;
        logic        run;
        logic        halt;
        logic [31:0] cnt;
    } outs_t;

    typedef struct {
        ins_t  i;
        outs_t e;
        string name;
    } vec_t;

    typedef struct {
        bit    sel;
        string name;
        outs_t exp;
    } sb_t;

    logic clk;
    ins_t in1;
    ins_t in2;
    sb_t  sbq[$];
    int   checks = 0;
    int   passes = 0;

    logic [3:0] boot1, boot2;
    logic [4:0] stage1, stage2, latch1, latch2;
    logic       mem1, mem2, io1, io2, prr1, prr2, run1, run2, halt1, halt2;
    logic [31:0] cnt1;
    logic [3:0]  cnt2;

    stage_sequencer dut (
        .clk(clk), .reset_n(in1.rst_n), .stall(in1.stall), .boot_step_done(in1.bsd),
        .halt_req(in1.hreq), .step_mode(in1.smode), .step_go(in1.sgo),
        .boot_active(boot1), .stage_active(stage1), .latch_enable(latch1),
        .mem_strobe(mem1), .io_enable(io1), .pipeline_register_reset_n(prr1),
        .running(run1), .halted(halt1), .retired_count(cnt1)
    );

    stage_sequencer #(.MEM_WAIT(2), .CNT_W(4)) dut_w (
        .clk(clk), .reset_n(in2.rst_n), .stall(in2.stall), .boot_step_done(in2.bsd),
        .halt_req(in2.hreq), .step_mode(in2.smode), .step_go(in2.sgo),
        .boot_active(boot2), .stage_active(stage2), .latch_enable(latch2),
        .mem_strobe(mem2), .io_enable(io2), .pipeline_register_reset_n(prr2),
        .running(run2), .halted(halt2), .retired_count(cnt2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic ins_t mk(input logic r, input logic s, input logic b,
                                input logic h, input logic m, input logic g);
        ins_t x;
        x.rst_n = r; x.stall = s; x.bsd = b; x.hreq = h; x.smode = m; x.sgo = g;
        return x;
    endfunction

    function automatic outs_t boot_o(input int k);
        outs_t o;
        o = '0;
        o.boot[k] = 1'b1;
        return o;
    endfunction

    function automatic outs_t sw_o(input int cnt);
        outs_t o;
        o = '0;
        o.io = 1'b1; o.prr = 1'b1; o.cnt = 32'(cnt);
        return o;
    endfunction

    function automatic outs_t halt_o(input int cnt);
        outs_t o;
        o = '0;
        o.prr = 1'b1; o.halt = 1'b1; o.cnt = 32'(cnt);
        return o;
    endfunction

    // Expected outputs at position p of a stall-free instruction (5 stages, memory stage 3)
    function automatic outs_t run_exp(input int p, input int mw, input int cnt);
        outs_t o;
        int q;
        bit done;
        o = '0;
        o.io = 1'b1; o.prr = 1'b1; o.run = 1'b1; o.cnt = 32'(cnt);
        q = p;
        done = 1'b0;
        for (int s = 0; s < 5; s++) begin
            int len;
            len = (s == 3) ? 1 + mw : 1;
            if (!done) begin
                if (q < len) begin
                    o.stage[s] = 1'b1;
                    o.mem = (s == 3) && (q == len - 1);
                    done = 1'b1;
                end else if (q == len) begin
                    o.latch[s] = 1'b1;
                    done = 1'b1;
                end else begin
                    q = q - len - 1;
                end
            end
        end
        return o;
    endfunction

    function automatic string fmt(input outs_t o);
        return $sformatf("boot=%b stage=%b latch=%b mem=%b io=%b prr_n=%b run=%b halt=%b cnt=%0d",
                         o.boot, o.stage, o.latch, o.mem, o.io, o.prr, o.run, o.halt, o.cnt);
    endfunction

    task automatic drive(input bit sel, input ins_t i, input outs_t e, input string nm, input bit chk);
        sb_t ent;
        @(posedge clk);
        #1;
        if (sel) in2 = i;
        else     in1 = i;
        if (chk) begin
            ent.sel = sel; ent.name = nm; ent.exp = e;
            sbq.push_back(ent);
        end
    endtask

    always @(negedge clk) begin
        sb_t   ent;
        outs_t act;
        if (sbq.size() > 0) begin
            ent = sbq.pop_front();
            if (ent.sel) act = {boot2, stage2, latch2, mem2, io2, prr2, run2, halt2, 28'd0, cnt2};
            else         act = {boot1, stage1, latch1, mem1, io1, prr1, run1, halt1, cnt1};
            checks++;
            if (act === ent.exp) passes++;
            else $display("FAIL %s: got %s required %s", ent.name, fmt(act), fmt(ent.exp));
        end
    end

    initial begin
        vec_t  v1[8];
        outs_t z;
        outs_t e;
        int    stall_at[10];

        z = '0;
        in1 = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        in2 = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        v1[0] = '{mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), z,         "reset"};
        v1[1] = '{mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), z,         "init"};
        v1[2] = '{mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1), boot_o(0), "boot0_hold"};
        v1[3] = '{mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), boot_o(0), "boot0"};
        v1[4] = '{mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), boot_o(1), "boot1"};
        v1[5] = '{mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0), boot_o(2), "boot2_stall"};
        v1[6] = '{mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), boot_o(2), "boot2"};
        v1[7] = '{mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1), boot_o(3), "boot3"};
        stall_at = '{0, 0, 0, 4, 0, 0, 1, 0, 0, 2};

        // Default instance: boot and three free-running instructions
        drive(1'b0, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), z, "pre_reset", 1'b0);
        for (int k = 0; k < 8; k++) drive(1'b0, v1[k].i, v1[k].e, v1[k].name, 1'b1);
        for (int k = 0; k < 30; k++)
            drive(1'b0, mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1), run_exp(k % 10, 0, k / 10), "free_run", 1'b1);

        // Stalls in LATCH(1), on the memory strobe cycle and in LATCH(4)
        for (int p = 0; p < 10; p++) begin
            for (int n = 0; n < stall_at[p]; n++) begin
                e = run_exp(p, 0, 3);
                e.latch = 5'b00000;
                e.mem = 1'b0;
                drive(1'b0, mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0), e, "stalled", 1'b1);
            end
            drive(1'b0, mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), run_exp(p, 0, 3), "after_stall", 1'b1);
        end

        // Single-step: wait after each retire, release with step_go or by leaving step mode
        for (int p = 0; p < 10; p++)
            drive(1'b0, mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), run_exp(p, 0, 4), "step_run1", 1'b1);
        for (int n = 0; n < 3; n++)
            drive(1'b0, mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0), sw_o(5), "step_wait1", 1'b1);
        drive(1'b0, mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1), sw_o(5), "step_go", 1'b1);
        for (int p = 0; p < 10; p++)
            drive(1'b0, mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), run_exp(p, 0, 5), "step_run2", 1'b1);
        for (int n = 0; n < 2; n++)
            drive(1'b0, mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), sw_o(6), "step_wait2", 1'b1);
        drive(1'b0, mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), sw_o(6), "step_mode_drop", 1'b1);
        for (int p = 0; p < 10; p++)
            drive(1'b0, mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0), run_exp(p, 0, 6), "halt_run", 1'b1);
        for (int n = 0; n < 3; n++)
            drive(1'b0, mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1), halt_o(7), "halted", 1'b1);
        drive(1'b0, mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), halt_o(7), "halt_reset_cycle", 1'b1);
        drive(1'b0, mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), z, "reset_from_halt", 1'b1);
        drive(1'b0, mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), boot_o(0), "reboot0", 1'b1);

        // MEM_WAIT=2, CNT_W=4 instance: fast boot, 17 instructions, reset mid-COMPUTE(2)
        drive(1'b1, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), z, "w_pre_reset", 1'b0);
        drive(1'b1, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), z, "w_reset", 1'b1);
        drive(1'b1, mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), z, "w_init", 1'b1);
        for (int k = 0; k < 4; k++)
            drive(1'b1, mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), boot_o(k), "w_boot", 1'b1);
        for (int n = 0; n < 17; n++) begin
            for (int p = 0; p < 12; p++) begin
                if (n == 1 && p == 7) begin
                    for (int s = 0; s < 2; s++)
                        drive(1'b1, mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), run_exp(7, 2, 1), "w_stall_memwait", 1'b1);
                end
                drive(1'b1, mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), run_exp(p, 2, n % 16), "w_run", 1'b1);
            end
        end
        for (int p = 0; p < 4; p++)
            drive(1'b1, mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), run_exp(p, 2, 1), "w_wrap", 1'b1);
        drive(1'b1, mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), run_exp(4, 2, 1), "w_reset_cycle", 1'b1);
        drive(1'b1, mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), z, "w_reset_mid_compute", 1'b1);

        @(negedge clk);
        #1;
        checks++;
        if (sbq.size() == 0) passes++;
        else $display("FAIL scoreboard_drain: got %0d pending required 0", sbq.size());
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
